// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch
// requester and a load/store requester. Only one transaction is outstanding
// at a time. A grant is a single combinational cycle in IDLE, and completion
// is signalled by a one-cycle rvalid pulse to the owner.
// Build option: define MEM_PORT_ARBITER_ROUND_ROBIN_EN to alternate between
// the requesters when both ask at once. Without it, data always beats fetch.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // Owner of the outstanding transaction: 0 = fetch, 1 = data
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;

    logic              grant;
    logic              pick_data;

`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
    logic              favour_data_q;

    assign pick_data = d_req & (~if_req | favour_data_q);

    // After each grant, favour the requester that did not just win
    always_ff @(posedge clk) begin
        if (!rst) begin
            favour_data_q <= 1'b1;
        end else if (grant) begin
            favour_data_q <= if_gnt;
        end
    end
`else
    assign pick_data = d_req;
`endif

    // A grant is only possible in IDLE and never while reset is held
    assign grant = (state == IDLE) && rst && (if_req || d_req);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: IDLE to BUSY on a grant, BUSY back to IDLE on mem_ready
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the winner's command in the grant cycle. Later input changes do not affect the transaction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_q <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (grant) begin
            owner_q <= pick_data;
            addr_q  <= pick_data ? d_addr : if_addr;
            we_q    <= pick_data & d_we;
            wdata_q <= pick_data ? d_wdata : '0;
        end
    end

    // Outputs: grants, memory command and completion pulses. All are held at 0 while reset is asserted.
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        if (grant) begin
            d_gnt  = pick_data;
            if_gnt = ~pick_data;
        end
        if ((state == BUSY) && rst) begin
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            if (mem_ready) begin
                if (owner_q) begin
                    d_rvalid = 1'b1;
                    d_rdata  = mem_rdata;
                end else begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter. Each step drives
// the inputs for one clock cycle just after the falling edge. It then checks
// the outputs mid-cycle, against values worked out by hand. It follows
// MEM_PORT_ARBITER_ROUND_ROBIN_EN when the design is built with it.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Drive one cycle of inputs after the falling edge, then settle before checks
    task automatic applyStimulus(input logic r, input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic dw, input logic [31:0] da,
                                 input logic [31:0] dwd, input logic mr, input logic [31:0] mrd);
        @(negedge clk);
        rst       = r;
        if_req    = ir;
        if_addr   = ia;
        d_req     = dr;
        d_we      = dw;
        d_addr    = da;
        d_wdata   = dwd;
        mem_ready = mr;
        mem_rdata = mrd;
        #1;
    endtask

    // One comparison: count it, and report and count it when it differs
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence: reset, fetch, simultaneous, store with waits, input change, busy request, reset abort
    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;

        // Reset held with activity on every input: everything stays 0
        applyStimulus(1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h20, 32'h30, 1'b1, 32'h40);
        checkOutput("rst_if_gnt", 32'(if_gnt), 32'd0);
        checkOutput("rst_d_gnt", 32'(d_gnt), 32'd0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h20, 32'h30, 1'b1, 32'h40);
        checkOutput("rst2_mem_addr", mem_addr, 32'd0);
        // Out of reset, idle, mem_ready is ignored
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h44);
        checkOutput("idle_mem_req", 32'(mem_req), 32'd0);
        checkOutput("idle_if_rvalid", 32'(if_rvalid), 32'd0);
        checkOutput("idle_d_rvalid", 32'(d_rvalid), 32'd0);
        checkOutput("idle_d_rdata", d_rdata, 32'd0);

        // Single fetch
        applyStimulus(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("f_if_gnt", 32'(if_gnt), 32'd1);
        checkOutput("f_d_gnt", 32'(d_gnt), 32'd0);
        checkOutput("f_mem_req0", 32'(mem_req), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h13);
        checkOutput("f_mem_req1", 32'(mem_req), 32'd1);
        checkOutput("f_mem_addr", mem_addr, 32'h10);
        checkOutput("f_mem_we", 32'(mem_we), 32'd0);
        checkOutput("f_if_rvalid", 32'(if_rvalid), 32'd1);
        checkOutput("f_if_rdata", if_rdata, 32'h13);
        checkOutput("f_d_rvalid", 32'(d_rvalid), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h13);
        checkOutput("f_after_mem_req", 32'(mem_req), 32'd0);
        checkOutput("f_after_if_rvalid", 32'(if_rvalid), 32'd0);
        checkOutput("f_after_if_rdata", if_rdata, 32'd0);

        // Simultaneous requests for two transactions: data first either way
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0);
        checkOutput("s1_d_gnt", 32'(d_gnt), 32'd1);
        checkOutput("s1_if_gnt", 32'(if_gnt), 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 32'h55);
        checkOutput("s1_mem_addr", mem_addr, 32'h80);
        checkOutput("s1_d_rvalid", 32'(d_rvalid), 32'd1);
        checkOutput("s1_d_rdata", d_rdata, 32'h55);
        checkOutput("s1_busy_if_gnt", 32'(if_gnt), 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0);
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
        checkOutput("s2_if_gnt", 32'(if_gnt), 32'd1);
        checkOutput("s2_d_gnt", 32'(d_gnt), 32'd0);
`else
        checkOutput("s2_if_gnt", 32'(if_gnt), 32'd0);
        checkOutput("s2_d_gnt", 32'(d_gnt), 32'd1);
`endif
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h66);
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
        checkOutput("s2_mem_addr", mem_addr, 32'h40);
        checkOutput("s2_if_rvalid", 32'(if_rvalid), 32'd1);
        checkOutput("s2_if_rdata", if_rdata, 32'h66);
`else
        checkOutput("s2_mem_addr", mem_addr, 32'h80);
        checkOutput("s2_d_rvalid", 32'(d_rvalid), 32'd1);
        checkOutput("s2_d_rdata", d_rdata, 32'h66);
`endif
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("s_idle_mem_req", 32'(mem_req), 32'd0);

        // Store with three wait states; d_wdata changes after the grant
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, 32'h0);
        checkOutput("st_d_gnt", 32'(d_gnt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h1234, (i == 3), 32'hAAAA);
            checkOutput($sformatf("st_mem_we_%0d", i), 32'(mem_we), 32'd1);
            checkOutput($sformatf("st_mem_wdata_%0d", i), mem_wdata, 32'hDEAD_BEEF);
            checkOutput($sformatf("st_mem_addr_%0d", i), mem_addr, 32'h100);
            checkOutput($sformatf("st_d_rvalid_%0d", i), 32'(d_rvalid), (i == 3) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("st_idle_d_rvalid", 32'(d_rvalid), 32'd0);
        checkOutput("st_idle_mem_we", 32'(mem_we), 32'd0);

        // Address change after the grant has no effect
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0);
        checkOutput("ac_d_gnt", 32'(d_gnt), 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
        checkOutput("ac_mem_addr1", mem_addr, 32'h200);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h300, 32'h0, 1'b1, 32'h77);
        checkOutput("ac_mem_addr2", mem_addr, 32'h200);
        checkOutput("ac_d_rdata", d_rdata, 32'h77);

        // Fetch request arriving during a data load waits for the next IDLE
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 32'h0);
        checkOutput("rb_d_gnt", 32'(d_gnt), 32'd1);
        applyStimulus(1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("rb_busy_if_gnt1", 32'(if_gnt), 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h88);
        checkOutput("rb_d_rvalid", 32'(d_rvalid), 32'd1);
        checkOutput("rb_busy_if_gnt2", 32'(if_gnt), 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("rb_idle_if_gnt", 32'(if_gnt), 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h99);
        checkOutput("rb_mem_addr", mem_addr, 32'h500);
        checkOutput("rb_if_rdata", if_rdata, 32'h99);

        // Reset in the second BUSY cycle aborts the load
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h600, 32'h0, 1'b0, 32'h0);
        checkOutput("ra_d_gnt", 32'(d_gnt), 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("ra_busy_mem_req", 32'(mem_req), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hBB);
        checkOutput("ra_rst_d_rvalid", 32'(d_rvalid), 32'd0);
        checkOutput("ra_rst_if_rvalid", 32'(if_rvalid), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hBB);
        checkOutput("ra_after_mem_req", 32'(mem_req), 32'd0);
        checkOutput("ra_after_d_rvalid", 32'(d_rvalid), 32'd0);
        checkOutput("ra_after_mem_addr", mem_addr, 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("ra_idle_if_gnt", 32'(if_gnt), 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hCC);
        checkOutput("ra_new_if_rvalid", 32'(if_rvalid), 32'd1);
        checkOutput("ra_new_mem_addr", mem_addr, 32'h700);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
